clk_gate_ctrl: RTL
==================

Name: clk_gate_ctrl

Overview:
Idle-driven clock-gating controller that produces the enable fed to the clock-gating AND cell (via the downstream enable latch) for one gated domain. It counts consecutive idle cycles of the domain and runs a sleep request/acknowledge handshake before removing the clock. It restores the clock on a wake request and holds the domain not-ready for a fixed settle time. It runs entirely on the free-running clock upstream of the gate.

Parameters:
IDLE_CYCLES, 16, consecutive idle cycles required before requesting sleep (>=1)
WAKE_CYCLES, 2, cycles the clock runs after wake before ready_o asserts (>=1)
CNT_W, $clog2(max(IDLE_CYCLES,WAKE_CYCLES)+1), shared counter width (derived, do not override)

Ports:
clk_i  input  1  free-running clock
rst_ni  input  1  reset, synchronous, active-low
busy_i  input  1  gated domain has work in flight
wakeup_i  input  1  level wake/activity request from outside the domain
sleep_ack_i  input  1  gated domain confirms quiescence for sleep
test_en_i  input  1  DFT override, forces clock enable
sleep_req_o  output  1  sleep request to gated domain
clk_en_o  output  1  enable to gate cell input (through enable latch)
ready_o  output  1  gated domain clocked and usable
state_o  output  2  debug: 0=ON, 1=REQ, 2=OFF, 3=WAKE

Behaviour:
- Moore FSM; all outputs decode from registered state except test_en_i OR term. clk_en_o = en_q | test_en_i, where en_q = (state != OFF).
- Reset (rst_ni=0 at posedge, any state): state=ON, cnt=0. Outputs: sleep_req_o=0, clk_en_o=1, ready_o=1, state_o=0. Reset mid-handshake drops sleep_req_o the next cycle with no ack required.
- activity = busy_i | wakeup_i.
- ON: ready_o=1, clk_en_o=1, sleep_req_o=0. activity -> cnt<=0. Otherwise, if cnt==IDLE_CYCLES-1 -> REQ, cnt<=0; else cnt<=cnt+1. REQ is entered exactly IDLE_CYCLES consecutive idle cycles after idle begins.
- REQ: sleep_req_o=1, clk_en_o=1, ready_o=1. activity -> ON, cnt<=0 (abort). If no activity and sleep_ack_i=1 -> OFF. Simultaneous activity and ack: abort wins.
- OFF: clk_en_o=0 (first cycle in OFF), sleep_req_o=0, ready_o=0. busy_i and sleep_ack_i ignored. wakeup_i -> WAKE, cnt<=0.
- WAKE: clk_en_o=1, ready_o=0, sleep_req_o=0. cnt increments each cycle. At cnt==WAKE_CYCLES-1 -> ON, cnt<=0, so ready_o rises WAKE_CYCLES cycles after clk_en_o rises. wakeup_i and busy_i are ignored in WAKE.
- Latency: idle start to sleep_req_o = IDLE_CYCLES cycles. Ack sampled to clk_en_o=0 = 1 cycle. wakeup_i sampled to clk_en_o=1 = 1 cycle.
- sleep_ack_i asserted outside REQ has no effect. Counter never exceeds its limit and never wraps.
- test_en_i=1 forces clk_en_o=1 combinationally and does not alter the FSM. ready_o still follows the FSM.
- clk_en_o changes only after the rising clock edge. The glitch-free latch lives downstream and is not part of this block.

Test Plan:
- Reset with busy_i=1 -> state_o=0, clk_en_o=1, ready_o=1, sleep_req_o=0.
- IDLE_CYCLES=4: busy_i falls at cycle 0 -> sleep_req_o=1 at cycle 4. sleep_ack_i=1 at cycle 6 -> clk_en_o=0, ready_o=0, state_o=2 at cycle 7.
- Idle-count abort: busy_i pulses high at idle cycle 3 (IDLE_CYCLES=4) -> count restarts, sleep_req_o rises 4 cycles after the pulse ends. Abort in REQ: busy_i=1 together with sleep_ack_i=1 -> state_o=0 next cycle, clk_en_o stays 1.
- Wake, WAKE_CYCLES=2: wakeup_i=1 in OFF at cycle N -> clk_en_o=1 and ready_o=0 at N+1, ready_o=1 at N+3, state_o=0.
- test_en_i=1 in OFF -> clk_en_o=1 immediately, state_o stays 2, ready_o=0. Release -> clk_en_o=0.
- rst_ni=0 for one cycle while in OFF and while in REQ -> next cycle state_o=0, clk_en_o=1, sleep_req_o=0, cnt restarts from 0.

Source files
------------

// File: rtl/clk_gate_ctrl.sv
// ============================================================================
// clk_gate_ctrl : idle-driven clock-gate enable controller with sleep handshake
// Revision 1.0
// ============================================================================
`default_nettype none

module clk_gate_ctrl #(
   parameter int IDLE_CYCLES = 16,
   parameter int WAKE_CYCLES = 2,
   parameter int CNT_W = $clog2(((IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES) + 1)
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       busy_i,
   input  logic       wakeup_i,
   input  logic       sleep_ack_i,
   input  logic       test_en_i,
   output logic       sleep_req_o,
   output logic       clk_en_o,
   output logic       ready_o,
   output logic [1:0] state_o
);

   localparam logic [1:0] S_ON   = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_OFF  = 2'd2;
   localparam logic [1:0] S_WAKE = 2'd3;

   localparam logic [CNT_W-1:0] C_IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             activity;

   assign activity = busy_i | wakeup_i;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_ON: begin
            if (activity) begin
               cnt_d = '0;
            end else if (cnt_q == C_IDLE_LAST) begin
               state_d = S_REQ;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + C_ONE;
            end
         end
         S_REQ: begin
            // Activity beats a coincident ack so the domain is never cut mid-work.
            if (activity) begin
               state_d = S_ON;
               cnt_d   = '0;
            end else if (sleep_ack_i) begin
               state_d = S_OFF;
            end
         end
         S_OFF: begin
            if (wakeup_i) begin
               state_d = S_WAKE;
               cnt_d   = '0;
            end
         end
         S_WAKE: begin
            if (cnt_q == C_WAKE_LAST) begin
               state_d = S_ON;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + C_ONE;
            end
         end
         default: begin
            state_d = S_ON;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= S_ON;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign sleep_req_o = (state_q == S_REQ);
   assign clk_en_o    = (state_q != S_OFF) | test_en_i;
   assign ready_o     = (state_q == S_ON) | (state_q == S_REQ);
   assign state_o     = state_q;

endmodule

`default_nettype wire
